// File: rtl/pool_pkg.sv
// Shared pool-table constants, fixed-point widths and ball FSM encoding,
// used by the ball motion, sprite and collision blocks.
package pool_pkg;

    localparam int RADIUS       = 16;
    localparam int TABLE_LEFT   = 64;
    localparam int TABLE_RIGHT  = 960;
    localparam int TABLE_TOP    = 64;
    localparam int TABLE_BOTTOM = 704;

    // Position is 11.4 unsigned fixed point; velocity is signed 1/16 px per frame.
    localparam int POS_INT_W  = 11;
    localparam int POS_FRAC_W = 4;
    localparam int POS_W      = POS_INT_W + POS_FRAC_W;
    localparam int VEL_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        STEP,
        DECAY
    } ball_state_t;

    // -128 has no positive counterpart, so it would not survive a bounce negation.
    function automatic logic signed [VEL_W-1:0] sat_vel(input logic [VEL_W-1:0] v);
        return (v == 8'h80) ? 8'sh81 : signed'(v);
    endfunction

    function automatic logic [POS_INT_W-1:0] clamp_pos(
        input logic [POS_INT_W-1:0] v,
        input logic [POS_INT_W-1:0] lo,
        input logic [POS_INT_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Falling-edge detector on the active-low vsync: one-cycle tick per frame.
module frame_tick (
    input  logic vclock,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;

    // History resets high so a vsync already low after reset still counts as a frame.
    always_ff @(posedge vclock) begin
        if (reset) begin
            vsync_q <= 1'b1;
            tick    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            tick    <= vsync_q & ~vsync;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball kinematics: strike/place in IDLE, one position step per video frame,
// cushion bounces and periodic friction until the ball comes to rest.
module ball_motion #(
    parameter int RADIUS          = pool_pkg::RADIUS,
    parameter int TABLE_LEFT      = pool_pkg::TABLE_LEFT,
    parameter int TABLE_RIGHT     = pool_pkg::TABLE_RIGHT,
    parameter int TABLE_TOP       = pool_pkg::TABLE_TOP,
    parameter int TABLE_BOTTOM    = pool_pkg::TABLE_BOTTOM,
    parameter int INIT_X          = 300,
    parameter int INIT_Y          = 400,
    parameter int FRICTION_PERIOD = 4
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        strike,
    input  logic [7:0]  strike_vx,
    input  logic [7:0]  strike_vy,
    input  logic        place,
    input  logic [10:0] place_x,
    input  logic [10:0] place_y,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [7:0]  vx,
    output logic [7:0]  vy,
    output logic        moving
);
    import pool_pkg::*;

    localparam int          FC_W    = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRICTION_PERIOD - 1);
    localparam logic [10:0] X_MIN   = 11'(TABLE_LEFT + RADIUS);
    localparam logic [10:0] X_MAX   = 11'(TABLE_RIGHT - RADIUS);
    localparam logic [10:0] Y_MIN   = 11'(TABLE_TOP + RADIUS);
    localparam logic [10:0] Y_MAX   = 11'(TABLE_BOTTOM - RADIUS);
    localparam logic [10:0] INIT_XI = 11'(INIT_X);
    localparam logic [10:0] INIT_YI = 11'(INIT_Y);

    ball_state_t       state, state_nx;
    logic [14:0]       pos_x, pos_y;
    logic signed [7:0] vel_x, vel_y;
    logic [FC_W-1:0]   fcnt;
    logic              tick;

    logic              strike_go, fc_wrap;
    logic [15:0]       sum_x, sum_y;
    logic              lo_x, hi_x, lo_y, hi_y;
    logic [14:0]       step_x, step_y;
    logic signed [7:0] step_vx, step_vy, dec_vx, dec_vy;

    frame_tick u_frame_tick (
        .vclock (vclock),
        .reset  (reset),
        .vsync  (vsync),
        .tick   (tick)
    );

    assign strike_go = strike && ((strike_vx != 8'd0) || (strike_vy != 8'd0));
    assign fc_wrap   = (fcnt == FC_LAST);

    // Step arithmetic is 16-bit so a (theoretical) underflow shows up as bit 15.
    always_comb begin
        sum_x   = {1'b0, pos_x} + {{8{vel_x[7]}}, vel_x};
        sum_y   = {1'b0, pos_y} + {{8{vel_y[7]}}, vel_y};
        lo_x    = sum_x[15] || (sum_x[14:4] < X_MIN);
        hi_x    = !sum_x[15] && (sum_x[14:4] > X_MAX);
        lo_y    = sum_y[15] || (sum_y[14:4] < Y_MIN);
        hi_y    = !sum_y[15] && (sum_y[14:4] > Y_MAX);
        step_x  = lo_x ? {X_MIN, 4'b0} : (hi_x ? {X_MAX, 4'b0} : sum_x[14:0]);
        step_y  = lo_y ? {Y_MIN, 4'b0} : (hi_y ? {Y_MAX, 4'b0} : sum_y[14:0]);
        step_vx = (lo_x || hi_x) ? -vel_x : vel_x;
        step_vy = (lo_y || hi_y) ? -vel_y : vel_y;
        dec_vx  = vel_x;
        dec_vy  = vel_y;
        if (fc_wrap && vel_x != 8'sd0) dec_vx = vel_x[7] ? vel_x + 8'sd1 : vel_x - 8'sd1;
        if (fc_wrap && vel_y != 8'sd0) dec_vy = vel_y[7] ? vel_y + 8'sd1 : vel_y - 8'sd1;
    end

    always_ff @(posedge vclock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (strike_go) state_nx = WAIT_FRAME;
            WAIT_FRAME: if (tick) state_nx = STEP;
            STEP:       state_nx = DECAY;
            DECAY:      state_nx = (dec_vx == 8'sd0 && dec_vy == 8'sd0) ? IDLE : WAIT_FRAME;
            default:    state_nx = IDLE;
        endcase
    end

    // Place and strike act on separate registers, so a same-cycle pair launches from the new spot.
    always_ff @(posedge vclock) begin
        if (reset) begin
            pos_x <= {INIT_XI, 4'b0};
            pos_y <= {INIT_YI, 4'b0};
            vel_x <= 8'sd0;
            vel_y <= 8'sd0;
            fcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (place) begin
                        pos_x <= {clamp_pos(place_x, X_MIN, X_MAX), 4'b0};
                        pos_y <= {clamp_pos(place_y, Y_MIN, Y_MAX), 4'b0};
                    end
                    if (strike_go) begin
                        vel_x <= sat_vel(strike_vx);
                        vel_y <= sat_vel(strike_vy);
                    end
                end
                STEP: begin
                    pos_x <= step_x;
                    pos_y <= step_y;
                    vel_x <= step_vx;
                    vel_y <= step_vy;
                end
                DECAY: begin
                    vel_x <= dec_vx;
                    vel_y <= dec_vy;
                    if (state_nx == IDLE || fc_wrap) fcnt <= '0;
                    else                             fcnt <= fcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        x      = pos_x[14:4];
        y      = pos_y[14:4];
        vx     = vel_x;
        vy     = vel_y;
        moving = (vel_x != 8'sd0) || (vel_y != 8'sd0);
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed testbench for ball_motion: reset, friction, cushions, corner,
// command gating and reset in the middle of a step.
module tb_ball_motion;

    logic        vclock = 1'b0;
    logic        reset  = 1'b1;
    logic        vsync  = 1'b1;
    logic        strike = 1'b0;
    logic [7:0]  strike_vx = 8'd0;
    logic [7:0]  strike_vy = 8'd0;
    logic        place  = 1'b0;
    logic [10:0] place_x = 11'd0;
    logic [10:0] place_y = 11'd0;
    logic [10:0] x, y;
    logic [7:0]  vx, vy;
    logic        moving;

    int errors = 0;
    int checks = 0;

    ball_motion dut (
        .vclock    (vclock),
        .reset     (reset),
        .vsync     (vsync),
        .strike    (strike),
        .strike_vx (strike_vx),
        .strike_vy (strike_vy),
        .place     (place),
        .place_x   (place_x),
        .place_y   (place_y),
        .x         (x),
        .y         (y),
        .vx        (vx),
        .vy        (vy),
        .moving    (moving)
    );

    always #5 vclock = ~vclock;

    task automatic do_reset();
        @(negedge vclock);
        reset = 1'b1;
        vsync = 1'b1;
        repeat (2) @(negedge vclock);
        reset = 1'b0;
    endtask

    // One-cycle command pulse; returns at the negedge after it was sampled.
    task automatic cmd(input logic s, input logic [7:0] svx, input logic [7:0] svy,
                       input logic p, input logic [10:0] px, input logic [10:0] py);
        @(negedge vclock);
        strike = s; strike_vx = svx; strike_vy = svy;
        place = p;  place_x = px;    place_y = py;
        @(negedge vclock);
        strike = 1'b0; place = 1'b0;
    endtask

    // vsync low pulse, then enough cycles for tick -> STEP -> DECAY to finish.
    task automatic do_frame();
        @(negedge vclock);
        vsync = 1'b0;
        repeat (2) @(negedge vclock);
        vsync = 1'b1;
        repeat (4) @(negedge vclock);
    endtask

    task automatic test_reset();
        @(negedge vclock);
        reset = 1'b1;
        repeat (2) @(negedge vclock);
        checks++; if (x !== 11'd300) begin errors++; $display("[TB] FAIL reset_x got=%0d exp=300", x); end
        checks++; if (y !== 11'd400) begin errors++; $display("[TB] FAIL reset_y got=%0d exp=400", y); end
        checks++; if (vx !== 8'd0) begin errors++; $display("[TB] FAIL reset_vx got=%0d exp=0", vx); end
        checks++; if (vy !== 8'd0) begin errors++; $display("[TB] FAIL reset_vy got=%0d exp=0", vy); end
        checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL reset_moving got=%0b exp=0", moving); end
        reset = 1'b0;
    endtask

    task automatic test_friction();
        do_reset();
        cmd(1'b1, 8'd32, 8'd0, 1'b0, 11'd0, 11'd0);
        checks++; if (moving !== 1'b1) begin errors++; $display("[TB] FAIL fric_moving_start got=%0b exp=1", moving); end
        do_frame();
        checks++; if (x !== 11'd302) begin errors++; $display("[TB] FAIL fric_x_tick1 got=%0d exp=302", x); end
        checks++; if (vx !== 8'd32) begin errors++; $display("[TB] FAIL fric_vx_tick1 got=%0d exp=32", vx); end
        repeat (3) do_frame();
        checks++; if (vx !== 8'd31) begin errors++; $display("[TB] FAIL fric_vx_tick4 got=%0d exp=31", vx); end
        checks++; if (x !== 11'd308) begin errors++; $display("[TB] FAIL fric_x_tick4 got=%0d exp=308", x); end
        repeat (123) do_frame();
        checks++; if (vx !== 8'd1) begin errors++; $display("[TB] FAIL fric_vx_tick127 got=%0d exp=1", vx); end
        do_frame();
        checks++; if (vx !== 8'd0) begin errors++; $display("[TB] FAIL fric_vx_tick128 got=%0d exp=0", vx); end
        checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL fric_moving_end got=%0b exp=0", moving); end
        checks++; if (x !== 11'd432) begin errors++; $display("[TB] FAIL fric_x_end got=%0d exp=432", x); end
    endtask

    task automatic test_zero_strike();
        do_reset();
        cmd(1'b1, 8'd0, 8'd0, 1'b0, 11'd0, 11'd0);
        checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL zero_strike_moving got=%0b exp=0", moving); end
        cmd(1'b1, 8'd16, 8'd0, 1'b0, 11'd0, 11'd0);
        do_frame();
        checks++; if (x !== 11'd301) begin errors++; $display("[TB] FAIL zero_then_strike_x got=%0d exp=301", x); end
    endtask

    task automatic test_place_strike();
        do_reset();
        cmd(1'b1, 8'd16, 8'hF0, 1'b1, 11'd500, 11'd300);
        checks++; if (x !== 11'd500 || y !== 11'd300) begin errors++; $display("[TB] FAIL place_strike_pos got=%0d,%0d exp=500,300", x, y); end
        do_frame();
        checks++; if (x !== 11'd501 || y !== 11'd299) begin errors++; $display("[TB] FAIL place_strike_step got=%0d,%0d exp=501,299", x, y); end
    endtask

    task automatic test_right_cushion();
        do_reset();
        cmd(1'b0, 8'd0, 8'd0, 1'b1, 11'd942, 11'd400);
        checks++; if (x !== 11'd942) begin errors++; $display("[TB] FAIL cushion_place_x got=%0d exp=942", x); end
        cmd(1'b1, 8'd64, 8'd0, 1'b0, 11'd0, 11'd0);
        do_frame();
        checks++; if (x !== 11'd944) begin errors++; $display("[TB] FAIL cushion_x_tick1 got=%0d exp=944", x); end
        checks++; if (vx !== 8'hC0) begin errors++; $display("[TB] FAIL cushion_vx_tick1 got=%0h exp=c0", vx); end
        do_frame();
        checks++; if (x !== 11'd940) begin errors++; $display("[TB] FAIL cushion_x_tick2 got=%0d exp=940", x); end
    endtask

    task automatic test_corner();
        do_reset();
        cmd(1'b0, 8'd0, 8'd0, 1'b1, 11'd78, 11'd78);
        checks++; if (x !== 11'd80 || y !== 11'd80) begin errors++; $display("[TB] FAIL corner_place got=%0d,%0d exp=80,80", x, y); end
        cmd(1'b1, 8'hD0, 8'hD0, 1'b0, 11'd0, 11'd0);
        do_frame();
        checks++; if (x !== 11'd80 || y !== 11'd80) begin errors++; $display("[TB] FAIL corner_pos got=%0d,%0d exp=80,80", x, y); end
        checks++; if (vx !== 8'd48 || vy !== 8'd48) begin errors++; $display("[TB] FAIL corner_vel got=%0d,%0d exp=48,48", vx, vy); end
    endtask

    task automatic test_ignore();
        do_reset();
        cmd(1'b1, 8'd1, 8'd0, 1'b0, 11'd0, 11'd0);
        cmd(1'b1, 8'd100, 8'd0, 1'b1, 11'd100, 11'd100);
        checks++; if (vx !== 8'd1) begin errors++; $display("[TB] FAIL ignore_strike_vx got=%0d exp=1", vx); end
        checks++; if (x !== 11'd300) begin errors++; $display("[TB] FAIL ignore_place_x got=%0d exp=300", x); end
        repeat (4) do_frame();
        checks++; if (moving !== 1'b0) begin errors++; $display("[TB] FAIL ignore_stopped got=%0b exp=0", moving); end
        cmd(1'b1, 8'h80, 8'd0, 1'b1, 11'd2000, 11'd10);
        checks++; if (x !== 11'd944 || y !== 11'd80) begin errors++; $display("[TB] FAIL clamp_pos got=%0d,%0d exp=944,80", x, y); end
        checks++; if (vx !== 8'h81) begin errors++; $display("[TB] FAIL sat_vx got=%0h exp=81", vx); end
    endtask

    task automatic test_reset_in_step();
        do_reset();
        cmd(1'b1, 8'd32, 8'd0, 1'b0, 11'd0, 11'd0);
        do_frame();
        checks++; if (x !== 11'd302) begin errors++; $display("[TB] FAIL rstep_pre_x got=%0d exp=302", x); end
        @(negedge vclock);
        vsync = 1'b0;
        repeat (2) @(negedge vclock);
        reset = 1'b1;
        vsync = 1'b1;
        @(negedge vclock);
        checks++; if (x !== 11'd300 || y !== 11'd400) begin errors++; $display("[TB] FAIL rstep_pos got=%0d,%0d exp=300,400", x, y); end
        checks++; if (vx !== 8'd0 || moving !== 1'b0) begin errors++; $display("[TB] FAIL rstep_vel got=%0d,%0b exp=0,0", vx, moving); end
        reset = 1'b0;
        do_frame();
        checks++; if (x !== 11'd300 || moving !== 1'b0) begin errors++; $display("[TB] FAIL rstep_after_tick got=%0d,%0b exp=300,0", x, moving); end
    endtask

    initial begin
        test_reset();
        test_friction();
        test_zero_strike();
        test_place_strike();
        test_right_cushion();
        test_corner();
        test_ignore();
        test_reset_in_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
